// File: rtl/sram_pkg.sv
// Shared defaults and helpers for the 1RW+1R byte-masked SRAM model.
// Defining SRAM_OUT_REG_EN adds an output register stage (read latency 2).
package sram_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_ADDR_WIDTH = 7;
  localparam int unsigned SRAM_NUM_WMASKS = SRAM_DATA_WIDTH / 8;

`ifdef SRAM_OUT_REG_EN
  localparam int unsigned SRAM_RD_LATENCY = 2;
`else
  localparam int unsigned SRAM_RD_LATENCY = 1;
`endif

  // One byte-enable bit expands to the eight data-bit enables it covers.
  function automatic logic [7:0] byte_en_to_bits(input logic en);
    return {8{en}};
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Per-port read output pipeline: data/valid register, optional second stage, sync reset.
// The second stage exists when SRAM_RD_LATENCY is 2 (SRAM_OUT_REG_EN defined).
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int unsigned Width   = SRAM_DATA_WIDTH,
  parameter int unsigned Latency = SRAM_RD_LATENCY
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_data,
  output logic             o_valid
);

  logic [Width-1:0] r_data1;
  logic             r_valid1;

  // Data holds across idle cycles; only valid drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data1  <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_valid1 <= i_en;
      if (i_en) begin
        r_data1 <= i_data;
      end
    end
  end

  generate
    if (Latency > 1) begin : g_out_reg
      logic [Width-1:0] r_data2;
      logic             r_valid2;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_data2  <= '0;
          r_valid2 <= 1'b0;
        end else begin
          r_data2  <= r_data1;
          r_valid2 <= r_valid1;
        end
      end

      assign o_data  = r_data2;
      assign o_valid = r_valid2;
    end else begin : g_no_out_reg
      assign o_data  = r_data1;
      assign o_valid = r_valid1;
    end
  endgenerate

endmodule

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural SRAM macro: port 0 read/write with byte mask, port 1 read-only, one clock.
// Optional SRAM_OUT_REG_EN adds an output register stage on both read ports.
module sram_1rw1r_wmask
  import sram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter  int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter  int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH,
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision1
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_in0;
  logic                  w_in1;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_coll;
  logic [DATA_WIDTH-1:0] w_bmask;
  logic [DATA_WIDTH-1:0] w_rdata0;
  logic [DATA_WIDTH-1:0] w_rdata1;
  logic [DATA_WIDTH:0]   w_p1_data;

  assign w_in0 = {1'b0, addr0} < DEPTH_LIM;
  assign w_in1 = {1'b0, addr1} < DEPTH_LIM;
  assign w_wr0 = !csb0 && !web0 && !rst0;
  assign w_rd0 = !csb0 && web0;
  assign w_rd1 = !csb1;

  always_comb begin
    w_bmask = '0;
    for (int i = 0; i < int'(NUM_WMASKS); i++) begin
      w_bmask[8*i +: 8] = byte_en_to_bits(wmask0[i]);
    end
  end

  // Out-of-range writes are dropped; the array itself is never reset.
  always_ff @(posedge clk0) begin
    if (w_wr0 && w_in0) begin
      r_mem[addr0] <= (r_mem[addr0] & ~w_bmask) | (din0 & w_bmask);
    end
  end

  // Reads sample the pre-write array contents, giving read-before-write on port 1.
  assign w_rdata0 = w_in0 ? r_mem[addr0] : '0;
  assign w_rdata1 = w_in1 ? r_mem[addr1] : '0;
  assign w_coll   = w_rd1 && w_wr0 && w_in0 && (addr0 == addr1);

  sram_rd_pipe #(
    .Width   (DATA_WIDTH),
    .Latency (SRAM_RD_LATENCY)
  ) u_pipe0 (
    .i_clk   (clk0),
    .i_rst   (rst0),
    .i_en    (w_rd0),
    .i_data  (w_rdata0),
    .o_data  (dout0),
    .o_valid (dout0_valid)
  );

  // Collision rides as the top bit of port 1 data so it stays aligned through the pipe.
  sram_rd_pipe #(
    .Width   (DATA_WIDTH + 1),
    .Latency (SRAM_RD_LATENCY)
  ) u_pipe1 (
    .i_clk   (clk0),
    .i_rst   (rst0),
    .i_en    (w_rd1),
    .i_data  ({w_coll, w_rdata1}),
    .o_data  (w_p1_data),
    .o_valid (dout1_valid)
  );

  assign dout1      = w_p1_data[DATA_WIDTH-1:0];
  assign collision1 = dout1_valid && w_p1_data[DATA_WIDTH];

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Self-checking bench for sram_1rw1r_wmask (RAM_DEPTH=100): vector table, reset sequence,
// and randomized traffic checked against an array-plus-latency-queue reference model.
module tb_sram_1rw1r_wmask;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 100;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          csb0;
  logic          web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;
  logic          dout0_valid;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;
  logic          dout1_valid;
  logic          collision1;

  sram_1rw1r_wmask #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RAM_DEPTH  (DEPTH)
  ) dut (
    .clk0        (clk0),
    .rst0        (rst0),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .collision1  (collision1)
  );

  always #5 clk0 = ~clk0;

  typedef struct {
    logic [31:0] d0;
    logic        v0;
    logic [31:0] d1;
    logic        v1;
    logic        c;
  } res_t;

  typedef struct {
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [6:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [6:0]  addr1;
    res_t        exp;
  } vec_t;

  res_t        hist[$];
  logic [31:0] mdl_mem[128];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          check_en = 1'b0;
  vec_t        tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mdl_read(input logic [6:0] a);
    return (int'(a) < DEPTH) ? mdl_mem[a] : 32'h0;
  endfunction

  // Reference: result of each edge's accesses, shown on the outputs LAT edges later.
  task automatic model_edge();
    res_t r;
    res_t prev;
    if (rst0) begin
      hist.delete();
      repeat (LAT) hist.push_back('{default: 0});
      return;
    end
    prev = hist[hist.size()-1];
    r.v0 = !csb0 && web0;
    r.d0 = r.v0 ? mdl_read(addr0) : prev.d0;
    r.v1 = !csb1;
    r.d1 = r.v1 ? mdl_read(addr1) : prev.d1;
    r.c  = r.v1 && !csb0 && !web0 && (int'(addr0) < DEPTH) && (addr0 == addr1);
    if (!csb0 && !web0 && int'(addr0) < DEPTH) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask0[i]) mdl_mem[addr0][8*i +: 8] = din0[8*i +: 8];
      end
    end
    hist.push_back(r);
    if (hist.size() > LAT) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk0);
    model_edge();
    #1;
    if (check_en) begin
      check("mdl_dout0", dout0, hist[0].d0);
      check("mdl_v0", 32'(dout0_valid), 32'(hist[0].v0));
      check("mdl_dout1", dout1, hist[0].d1);
      check("mdl_v1", 32'(dout1_valid), 32'(hist[0].v1));
      check("mdl_coll", 32'(collision1), 32'(hist[0].c));
    end
  endtask

  task automatic set_idle();
    rst0 = 1'b0; csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
  endtask

  function automatic vec_t mk(input logic c0, input logic w0, input logic [3:0] m,
                              input logic [6:0] a0, input logic [31:0] di, input logic c1,
                              input logic [6:0] a1, input logic [31:0] e0, input logic ev0,
                              input logic [31:0] e1, input logic ev1, input logic ec);
    vec_t v;
    v.csb0 = c0; v.web0 = w0; v.wmask0 = m; v.addr0 = a0; v.din0 = di;
    v.csb1 = c1; v.addr1 = a1;
    v.exp.d0 = e0; v.exp.v0 = ev0; v.exp.d1 = e1; v.exp.v1 = ev1; v.exp.c = ec;
    return v;
  endfunction

  initial begin
    //             csb0  web0  mask  addr0  din0          csb1  addr1  dout0 v0 dout1 v1 coll
    tbl[0]  = mk(1'b0, 1'b0, 4'hF, 7'h05, 32'hAABBCCDD, 1'b1, 7'h00,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b0, 4'h5, 7'h05, 32'h11223344, 1'b1, 7'h00,
                 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 4'h0, 7'h05, 32'h0, 1'b0, 7'h05,
                 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 4'hF, 7'h10, 32'h00000001, 1'b1, 7'h00,
                 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 4'hF, 7'h10, 32'hDEADBEEF, 1'b0, 7'h10,
                 32'hAA22CC44, 1'b0, 32'h00000001, 1'b1, 1'b1);
    tbl[5]  = mk(1'b1, 1'b1, 4'h0, 7'h00, 32'h0, 1'b0, 7'h10,
                 32'hAA22CC44, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 4'h0, 7'h10, 32'hFFFFFFFF, 1'b0, 7'h10,
                 32'hAA22CC44, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 4'hF, 7'd110, 32'h12345678, 1'b0, 7'd110,
                 32'hAA22CC44, 1'b0, 32'h0, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 4'h0, 7'd110, 32'h0, 1'b0, 7'h10,
                 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 4'h0, 7'h05, 32'h0, 1'b0, 7'h10,
                 32'hAA22CC44, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 4'h0, 7'h10, 32'h0, 1'b0, 7'h05,
                 32'hDEADBEEF, 1'b1, 32'hAA22CC44, 1'b1, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 4'h0, 7'h7F, 32'h0, 1'b0, 7'd100,
                 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);

    foreach (mdl_mem[i]) mdl_mem[i] = '0;
    repeat (LAT) hist.push_back('{default: 0});

    set_idle();
    rst0 = 1'b1;
    step();
    check_en = 1'b1;
    step();
    set_idle();
    step();
    check("rst_dout0", dout0, 32'h0);
    check("rst_v0", 32'(dout0_valid), 32'h0);
    check("rst_dout1", dout1, 32'h0);
    check("rst_v1", 32'(dout1_valid), 32'h0);
    check("rst_coll", 32'(collision1), 32'h0);

    for (int k = 0; k < 12; k++) begin
      rst0 = 1'b0;
      csb0 = tbl[k].csb0; web0 = tbl[k].web0; wmask0 = tbl[k].wmask0;
      addr0 = tbl[k].addr0; din0 = tbl[k].din0;
      csb1 = tbl[k].csb1; addr1 = tbl[k].addr1;
      step();
      for (int j = 1; j < LAT; j++) begin
        set_idle();
        step();
      end
      check($sformatf("tbl%0d_dout0", k), dout0, tbl[k].exp.d0);
      check($sformatf("tbl%0d_v0", k), 32'(dout0_valid), 32'(tbl[k].exp.v0));
      check($sformatf("tbl%0d_dout1", k), dout1, tbl[k].exp.d1);
      check($sformatf("tbl%0d_v1", k), 32'(dout1_valid), 32'(tbl[k].exp.v1));
      check($sformatf("tbl%0d_coll", k), 32'(collision1), 32'(tbl[k].exp.c));
    end

    // Reset right behind a read pair; a write presented during reset must be ignored.
    set_idle();
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'h05; csb1 = 1'b0; addr1 = 7'h10;
    step();
    rst0 = 1'b1; csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 7'h05; din0 = 32'h0;
    csb1 = 1'b0; addr1 = 7'h10;
    step();
    check("midrst_v0", 32'(dout0_valid), 32'h0);
    check("midrst_v1", 32'(dout1_valid), 32'h0);
    check("midrst_dout0", dout0, 32'h0);
    set_idle();
    step();
    check("postrst_v0", 32'(dout0_valid), 32'h0);
    check("postrst_v1", 32'(dout1_valid), 32'h0);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'h05; csb1 = 1'b0; addr1 = 7'h10;
    step();
    for (int j = 1; j < LAT; j++) begin
      set_idle();
      step();
    end
    check("keep_dout0", dout0, 32'hAA22CC44);
    check("keep_dout1", dout1, 32'hDEADBEEF);

    // Fill every in-range word so later random reads are fully defined.
    for (int a = 0; a < DEPTH; a++) begin
      set_idle();
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 7'(a); din0 = $urandom;
      step();
    end

    for (int i = 0; i < 128; i++) begin
      set_idle();
      csb0 = 1'b0; web0 = 1'b1; addr0 = 7'(i);
      csb1 = 1'b0; addr1 = 7'(127 - i);
      step();
      if (i >= LAT - 1) begin
        check("stream_v0", 32'(dout0_valid), 32'h1);
        check("stream_v1", 32'(dout1_valid), 32'h1);
      end
    end

    for (int i = 0; i < 600; i++) begin
      rst0   = ($urandom_range(0, 63) == 0);
      csb0   = ($urandom_range(0, 3) == 0);
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom_range(0, 15));
      addr0  = 7'($urandom_range(0, 127));
      din0   = $urandom;
      csb1   = ($urandom_range(0, 3) == 0);
      addr1  = ($urandom_range(0, 2) == 0) ? addr0 : 7'($urandom_range(0, 127));
      step();
    end

    set_idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
